alu_bus_seq: RTL

Multi-cycle micro-sequencer for the structural PIC datapath. It executes one register/W ALU instruction at a time over the shared tri-state 8-bit bus. Per cycle it drives exactly one bus source enable, the ALU operand load and opcode, the destination write strobe, and the carry/zero update strobes of the STATUS register. It sits between the instruction decoder (start/op/operand handshake) and the register file, W register and ALU.

---
 rtl/alu_bus_seq.sv | 131 +++++++++++++
 1 files changed

// File: rtl/alu_bus_seq.sv
// Multi-cycle micro-sequencer issuing one register/W ALU instruction over the
// shared 8-bit bus: READ -> EXEC -> WRITE, with CLRF skipping READ.
module alu_bus_seq #(
   parameter int NUM_REGS   = 8,
   parameter int SEL_W      = 3,
   parameter int STATUS_IDX = 3
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic [3:0]          op,
   input  logic [SEL_W-1:0]    f_sel,
   input  logic                d,
   output logic [NUM_REGS-1:0] out_en,
   output logic [NUM_REGS-1:0] write_en,
   output logic                w_out_en,
   output logic                w_write_en,
   output logic                alu_b_ld,
   output logic [3:0]          alu_op,
   output logic                alu_out_en,
   output logic                carry_wr,
   output logic                zero_wr,
   output logic                busy,
   output logic                done,
   output logic                err
);

   localparam logic [3:0] OP_MOVF  = 4'd0;
   localparam logic [3:0] OP_MOVWF = 4'd1;
   localparam logic [3:0] OP_ADDWF = 4'd2;
   localparam logic [3:0] OP_SUBWF = 4'd3;
   localparam logic [3:0] OP_ANDWF = 4'd4;
   localparam logic [3:0] OP_IORWF = 4'd5;
   localparam logic [3:0] OP_XORWF = 4'd6;
   localparam logic [3:0] OP_RLF   = 4'd7;
   localparam logic [3:0] OP_RRF   = 4'd8;
   localparam logic [3:0] OP_CLRF  = 4'd9;

   localparam logic [31:0] NUM_REGS_U   = NUM_REGS;
   localparam logic [31:0] STATUS_IDX_U = STATUS_IDX;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_EXEC,
      S_WRITE,
      S_ERR
   } state_t;

   state_t              state, state_nxt;
   logic [3:0]          op_q;
   logic [SEL_W-1:0]    sel_q;
   logic                d_q;
   logic                op_legal, sel_legal;
   logic [NUM_REGS-1:0] sel_oh;
   logic                to_file, status_dst, upd_c, upd_z;

   assign op_legal   = (op <= OP_CLRF);
   assign sel_legal  = (32'(f_sel) < NUM_REGS_U);
   assign sel_oh     = {{(NUM_REGS-1){1'b0}}, 1'b1} << sel_q;
   assign to_file    = d_q || (op_q == OP_MOVWF);
   // A full write to STATUS overrides the individual flag updates.
   assign status_dst = to_file && (32'(sel_q) == STATUS_IDX_U);
   assign upd_c      = op_q inside {OP_ADDWF, OP_SUBWF, OP_RLF, OP_RRF};
   assign upd_z      = op_q inside {OP_MOVF, OP_ADDWF, OP_SUBWF, OP_ANDWF,
                                    OP_IORWF, OP_XORWF, OP_CLRF};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         op_q  <= '0;
         sel_q <= '0;
         d_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && start) begin
            op_q  <= op;
            sel_q <= f_sel;
            d_q   <= d;
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      out_en     = '0;
      write_en   = '0;
      w_out_en   = 1'b0;
      w_write_en = 1'b0;
      alu_b_ld   = 1'b0;
      alu_op     = '0;
      alu_out_en = 1'b0;
      carry_wr   = 1'b0;
      zero_wr    = 1'b0;
      busy       = (state != S_IDLE);
      done       = 1'b0;
      err        = 1'b0;
      if (state != S_IDLE) alu_op = op_q;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (!op_legal || !sel_legal) state_nxt = S_ERR;
               else if (op == OP_CLRF)      state_nxt = S_EXEC;
               else                         state_nxt = S_READ;
            end
         end
         S_READ: begin
            alu_b_ld = 1'b1;
            if (op_q == OP_MOVWF) w_out_en = 1'b1;
            else                  out_en   = sel_oh;
            state_nxt = S_EXEC;
         end
         S_EXEC: state_nxt = S_WRITE;
         S_WRITE: begin
            alu_out_en = 1'b1;
            done       = 1'b1;
            if (to_file) write_en   = sel_oh;
            else         w_write_en = 1'b1;
            carry_wr  = upd_c && !status_dst;
            zero_wr   = upd_z && !status_dst;
            state_nxt = S_IDLE;
         end
         S_ERR: begin
            err       = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule
